// File: rtl/frame_draw_scheduler.sv
// frame_draw_scheduler: services enabled sprite slots once per frame tick,
// running an erase pass then a draw pass per slot with per-pass timeout.
module frame_draw_scheduler #(
    parameter int NUM_SLOTS = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic [NUM_SLOTS-1:0] slot_en,
    input  logic [NUM_SLOTS-1:0] drw_done,
    output logic [NUM_SLOTS-1:0] drw_start,
    output logic                 erase,
    output logic                 plot,
    output logic [2:0]           active_slot,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun,
    output logic                 timeout_err
);
    typedef enum logic [2:0] {IDLE, SCAN, START_ERASE, WAIT_ERASE, START_DRAW, WAIT_DRAW} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t               state, state_nx;
    logic [3:0]           ptr, ptr_nx;
    logic [NUM_SLOTS-1:0] mask, mask_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [7:0]           mask_pad, done_pad, onehot;
    logic                 waiting, starting, done_ok, expired, last;

    assign mask_pad = 8'(mask);
    assign done_pad = 8'(drw_done);
    assign onehot   = 8'd1 << ptr[2:0];
    assign waiting  = state == WAIT_ERASE || state == WAIT_DRAW;
    assign starting = state == START_ERASE || state == START_DRAW;
    // the first wait cycle ignores done so a drawer has time to drop it
    assign done_ok  = waiting && cnt != '0 && done_pad[ptr[2:0]];
    assign expired  = waiting && !done_ok && cnt == CW'(TIMEOUT - 1);
    assign last     = state == SCAN && ptr == 4'(NUM_SLOTS);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            mask  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            mask  <= mask_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        mask_nx  = mask;
        cnt_nx   = waiting ? cnt + 1'b1 : '0;
        unique case (state)
            IDLE: if (frame_tick) begin
                state_nx = SCAN;
                ptr_nx   = '0;
                mask_nx  = slot_en;
            end
            SCAN: begin
                if (last) state_nx = IDLE;
                else if (mask_pad[ptr[2:0]]) state_nx = START_ERASE;
                else ptr_nx = ptr + 4'd1;
            end
            START_ERASE: state_nx = WAIT_ERASE;
            START_DRAW:  state_nx = WAIT_DRAW;
            WAIT_ERASE: begin
                if (done_ok) state_nx = START_DRAW;
                else if (expired) begin
                    state_nx = SCAN;
                    ptr_nx   = ptr + 4'd1;
                end
            end
            WAIT_DRAW: if (done_ok || expired) begin
                state_nx = SCAN;
                ptr_nx   = ptr + 4'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // outputs are gated by reset so an abandoned frame emits nothing
    assign drw_start   = (starting && !reset) ? onehot[NUM_SLOTS-1:0] : '0;
    assign erase       = !reset && (state == START_ERASE || state == WAIT_ERASE);
    assign plot        = !reset && waiting && !done_pad[ptr[2:0]];
    assign active_slot = (!reset && (starting || waiting)) ? ptr[2:0] : 3'd0;
    assign busy        = !reset && state != IDLE;
    assign frame_done  = !reset && last;
    assign overrun     = busy && frame_tick && !last;
    assign timeout_err = !reset && expired;
endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb_frame_draw_scheduler: random frames against a per-frame timeline model
// built from slot masks and drawer latencies.
module tb_frame_draw_scheduler;
    localparam int T    = 64;
    localparam int FMAX = 1200;

    logic       clock = 0, reset = 1, frame_tick = 0;
    logic [7:0] slot_en = 0, drw_done, drw_start;
    logic       erase, plot, busy, frame_done, overrun, timeout_err;
    logic [2:0] active_slot;
    int         n_chk = 0, n_err = 0;
    int         le[8], ld[8];
    int         dcnt[8] = '{default: 0};

    frame_draw_scheduler dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .slot_en(slot_en),
        .drw_done(drw_done), .drw_start(drw_start), .erase(erase), .plot(plot),
        .active_slot(active_slot), .busy(busy), .frame_done(frame_done),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    // drawer i holds done low for a chosen latency after each start
    always @(posedge clock)
        for (int i = 0; i < 8; i++)
            if (drw_start[i]) dcnt[i] <= erase ? le[i] : ld[i];
            else if (dcnt[i] != 0) dcnt[i] <= dcnt[i] - 1;

    always_comb
        for (int i = 0; i < 8; i++) drw_done[i] = dcnt[i] == 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag, input bit with_act);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_start"}, drw_start, 0);
        check({tag, "_erase"}, erase, 0);
        check({tag, "_plot"}, plot, 0);
        check({tag, "_fd"}, frame_done, 0);
        check({tag, "_ovr"}, overrun, 0);
        check({tag, "_to"}, timeout_err, 0);
        if (with_act) check({tag, "_act"}, active_slot, 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            frame_tick = 0;
            slot_en = 8'($urandom);
            #1 check_quiet("idle", 0);
        end
    endtask

    function automatic int rlat();
        return ($urandom_range(0, 9) == 0) ? 200 : int'($urandom_range(1, 20));
    endfunction

    // ovr_at: -1 none, -2 random offset, else that offset; abort_at: reset offset or -1
    task automatic run_frame(input logic [7:0] m, input int ovr_at, input int abort_at, input bit coincide);
        int e_st[FMAX], e_er[FMAX], e_pl[FMAX], e_bs[FMAX], e_fd[FMAX], e_to[FMAX], e_act[FMAX];
        int c, s, s2, w, w2, ovr;
        for (int o = 0; o < FMAX; o++) begin
            e_st[o] = 0; e_er[o] = 0; e_pl[o] = 0; e_bs[o] = 0;
            e_fd[o] = 0; e_to[o] = 0; e_act[o] = -1;
        end
        c = 1;
        for (int i = 0; i < 8; i++) begin
            e_bs[c] = 1;
            if (!m[i]) begin
                c++;
                continue;
            end
            s = c + 1;
            e_st[s] = 1 << i; e_er[s] = 1; e_act[s] = i; e_bs[s] = 1;
            w = (le[i] + 1 < T) ? le[i] + 1 : T;
            for (int k = 0; k < w; k++) begin
                e_er[s+1+k] = 1; e_act[s+1+k] = i; e_bs[s+1+k] = 1;
                e_pl[s+1+k] = int'(k < le[i]);
            end
            if (le[i] >= T) begin
                e_to[s+w] = 1;
                c = s + 1 + w;
                continue;
            end
            s2 = s + 1 + w;
            e_st[s2] = 1 << i; e_act[s2] = i; e_bs[s2] = 1;
            w2 = (ld[i] + 1 < T) ? ld[i] + 1 : T;
            for (int k = 0; k < w2; k++) begin
                e_act[s2+1+k] = i; e_bs[s2+1+k] = 1;
                e_pl[s2+1+k] = int'(k < ld[i]);
            end
            if (ld[i] >= T) e_to[s2+w2] = 1;
            c = s2 + 1 + w2;
        end
        e_bs[c] = 1;
        e_fd[c] = 1;
        ovr = (ovr_at == -2) ? int'($urandom_range(1, c - 1)) : ovr_at;
        for (int o = 0; o <= c; o++) begin
            @(negedge clock);
            frame_tick = (o == 0) || (o == ovr) || (coincide && o == c);
            slot_en = (o == 0) ? m : 8'($urandom);
            reset = (o == abort_at);
            #1;
            if (o == abort_at) begin
                check_quiet("rst_during", 1);
                @(negedge clock);
                reset = 0;
                frame_tick = 0;
                #1 check_quiet("rst_after", 1);
                return;
            end
            check("busy", busy, e_bs[o]);
            check("start", drw_start, e_st[o]);
            check("erase", erase, e_er[o]);
            check("plot", plot, e_pl[o]);
            check("frame_done", frame_done, e_fd[o]);
            check("timeout", timeout_err, e_to[o]);
            check("overrun", overrun, int'(o == ovr));
            if (e_act[o] >= 0) check("active_slot", active_slot, e_act[o]);
        end
        @(negedge clock);
        frame_tick = 0;
    endtask

    task automatic set_lat(input int e, input int d);
        for (int i = 0; i < 8; i++) begin
            le[i] = e;
            ld[i] = d;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        set_lat(13, 13);
        repeat (2) @(negedge clock);
        #1 check_quiet("reset", 1);
        @(negedge clock);
        reset = 0;
        idle(2);
        run_frame(8'h05, -1, -1, 0);
        idle(1);
        run_frame(8'h00, -1, -1, 0);
        idle(1);
        le[1] = 200;
        run_frame(8'h02, -1, -1, 0);
        idle(1);
        set_lat(13, 13);
        run_frame(8'h08, 25, -1, 0);
        idle(1);
        le[1] = 200;
        run_frame(8'h02, -1, 6, 0);
        idle(1);
        set_lat(13, 13);
        run_frame(8'h03, -1, -1, 0);
        idle(1);
        run_frame(8'h01, -1, -1, 0);
        run_frame(8'hFF, -1, -1, 1);
        idle(2);
        for (int f = 0; f < 16; f++) begin
            for (int i = 0; i < 8; i++) begin
                le[i] = rlat();
                ld[i] = rlat();
            end
            run_frame(8'($urandom), ($urandom_range(0, 2) == 0) ? -2 : -1, -1, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
